gelato_warp_issue: RTL and testbench

Warp-scheduler issue stage and the driving side of the scoreboard record channel. Buffers one decoded instruction per warp, checks each against that warp's dirty-register snapshot, picks one hazard-free warp per cycle round-robin, and forwards it to the dispatch output register. In the same cycle it records the instruction's destination register into the scoreboard.

---
 rtl/gelato_types.sv | 28 ++
 rtl/gelato_rr_arbiter.sv | 37 +++
 rtl/gelato_warp_issue.sv | 137 +++++++++++++
 tb/tb_gelato_warp_issue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_types.sv
// gelato_types: shared issue-path types.
//   reg_num_t    - architectural register number (0 = "no register")
//   warp_num_t   - warp index
//   issue_inst_t - decoded instruction as buffered/issued by the warp scheduler
// WARP_NUM / SCOREBOARD_SIZE are global macros; fall back to the defaults here
// when the build has not defined them.
`ifndef WARP_NUM
`define WARP_NUM 4
`endif
`ifndef SCOREBOARD_SIZE
`define SCOREBOARD_SIZE 4
`endif

package gelato_types;
  localparam int REG_NUM_W  = 5;
  localparam int PAYLOAD_W  = 32;
  localparam int WARP_NUM_W = (`WARP_NUM > 1) ? $clog2(`WARP_NUM) : 1;

  typedef logic [REG_NUM_W-1:0]  reg_num_t;
  typedef logic [WARP_NUM_W-1:0] warp_num_t;

  typedef struct packed {
    reg_num_t               rd;
    reg_num_t               rs1;
    reg_num_t               rs2;
    logic [PAYLOAD_W-1:0]   payload;
  } issue_inst_t;
endpackage

// File: rtl/gelato_rr_arbiter.sv
// gelato_rr_arbiter: combinational round-robin arbiter.
//   req        - request vector
//   ptr        - last granted index; search starts at ptr+1 (mod N)
//   gnt_onehot - one-hot grant
//   gnt_idx    - binary grant index
//   any        - at least one request present
module gelato_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Walk from the farthest candidate back to ptr+1 so the nearest requester
  // is the last one written and therefore wins.
  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = IW'(idx);
        any             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gelato_warp_issue.sv
// gelato_warp_issue: warp-scheduler issue stage.
// Holds one decoded instruction per warp, blocks warps whose sources/dest hit
// the scoreboard snapshot (or whose scoreboard is full when a dest is needed),
// picks one eligible warp per cycle round-robin, records its rd into the
// scoreboard combinationally, and loads it into the dispatch output register.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   rdy                     - global enable; 0 freezes all state
//   inst_valid/ready/inst   - per-warp instruction intake
//   sb_regs                 - per-warp dirty-register snapshot (0 = empty)
//   rec_warp_num/new_reg    - scoreboard record (new_reg 0 = no record)
//   issue_valid/ready/warp/inst - dispatch output
//   stall_cnt               - saturating count of cycles buffered but not firing
module gelato_warp_issue
  import gelato_types::*;
#(
  parameter  int WARP_NUM        = `WARP_NUM,
  parameter  int SCOREBOARD_SIZE = `SCOREBOARD_SIZE,
  parameter  int REG_W           = REG_NUM_W,   // must match reg_num_t
  localparam int WW              = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              rdy,
  input  logic [WARP_NUM-1:0]                               inst_valid,
  output logic [WARP_NUM-1:0]                               inst_ready,
  input  issue_inst_t [WARP_NUM-1:0]                        inst,
  input  logic [WARP_NUM-1:0][SCOREBOARD_SIZE-1:0][REG_W-1:0] sb_regs,
  output logic [WW-1:0]                                     rec_warp_num,
  output logic [REG_W-1:0]                                  rec_new_reg,
  output logic                                              issue_valid,
  input  logic                                              issue_ready,
  output logic [WW-1:0]                                     issue_warp,
  output issue_inst_t                                       issue_inst,
  output logic [15:0]                                       stall_cnt
);

  issue_inst_t [WARP_NUM-1:0] ibuf_q, ibuf_d;
  logic [WARP_NUM-1:0] ibuf_v_q, ibuf_v_d;
  logic [WARP_NUM-1:0] hazard, cap_ok, eligible, gnt_onehot, sel_onehot;
  logic [WW-1:0]       rr_ptr_q, rr_ptr_d, gnt_idx;
  logic [WW-1:0]       issue_warp_q, issue_warp_d;
  logic                issue_valid_q, issue_valid_d;
  issue_inst_t         issue_inst_q, issue_inst_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic                any_gnt, can_fire;

  // Per-warp hazard/capacity. A nonzero slot can only equal a nonzero
  // register, so r0 never hazards without an explicit check.
  for (genvar w = 0; w < WARP_NUM; w++) begin : g_warp
    logic [SCOREBOARD_SIZE-1:0] slot_hit, slot_free;
    for (genvar j = 0; j < SCOREBOARD_SIZE; j++) begin : g_slot
      assign slot_free[j] = (sb_regs[w][j] == '0);
      assign slot_hit[j]  = !slot_free[j] &&
                            (sb_regs[w][j] == ibuf_q[w].rd  ||
                             sb_regs[w][j] == ibuf_q[w].rs1 ||
                             sb_regs[w][j] == ibuf_q[w].rs2);
    end
    assign hazard[w]   = |slot_hit;
    assign cap_ok[w]   = (ibuf_q[w].rd == '0) || (|slot_free);
    assign eligible[w] = ibuf_v_q[w] && !hazard[w] && cap_ok[w];
  end

  gelato_rr_arbiter #(.N(WARP_NUM)) u_arb (
    .req        (eligible),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any_gnt)
  );

  always_comb begin
    can_fire     = rdy && (!issue_valid_q || issue_ready) && any_gnt;
    sel_onehot   = can_fire ? gnt_onehot : '0;
    // A selected buffer drains on the same edge it may be refilled.
    inst_ready   = rdy ? (~ibuf_v_q | sel_onehot) : '0;
    rec_warp_num = can_fire ? gnt_idx : '0;
    rec_new_reg  = can_fire ? ibuf_q[gnt_idx].rd : '0;
  end

  always_comb begin
    ibuf_d        = ibuf_q;
    ibuf_v_d      = ibuf_v_q;
    rr_ptr_d      = rr_ptr_q;
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_inst_d  = issue_inst_q;
    stall_cnt_d   = stall_cnt_q;

    for (int w = 0; w < WARP_NUM; w++) begin
      if (inst_valid[w] && inst_ready[w]) begin
        ibuf_d[w]   = inst[w];
        ibuf_v_d[w] = 1'b1;
      end else if (sel_onehot[w]) begin
        ibuf_v_d[w] = 1'b0;
      end
    end

    if (can_fire) begin
      issue_valid_d = 1'b1;
      issue_warp_d  = gnt_idx;
      issue_inst_d  = ibuf_q[gnt_idx];
      rr_ptr_d      = gnt_idx;
    end else if (rdy && issue_ready) begin
      issue_valid_d = 1'b0;
    end

    if (rdy && (|ibuf_v_q) && !can_fire && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ibuf_q        <= '0;
      ibuf_v_q      <= '0;
      rr_ptr_q      <= WW'(WARP_NUM - 1);  // warp 0 wins first
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_inst_q  <= '0;
      stall_cnt_q   <= '0;
    end else begin
      ibuf_q        <= ibuf_d;
      ibuf_v_q      <= ibuf_v_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_inst_q  <= issue_inst_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_inst  = issue_inst_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_gelato_warp_issue.sv
// Directed bench for gelato_warp_issue (4 warps, 4 slots, 5-bit regs).
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_gelato_warp_issue;
  import gelato_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic issue_ready = 1'b1;
  logic [3:0] inst_valid = '0;
  logic [3:0] inst_ready;
  issue_inst_t [3:0] inst;
  logic [3:0][3:0][4:0] sb_regs;
  logic [1:0] rec_warp_num, issue_warp;
  logic [4:0] rec_new_reg;
  logic issue_valid;
  issue_inst_t issue_inst;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gelato_warp_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .sb_regs      (sb_regs),
    .rec_warp_num (rec_warp_num),
    .rec_new_reg  (rec_new_reg),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_warp   (issue_warp),
    .issue_inst   (issue_inst),
    .stall_cnt    (stall_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_reset;
    inst_valid = '0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    smp;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b exp 0", issue_valid); end
    checks++; if (issue_warp !== 2'd0) begin errors++; $display("FAIL reset_issue_warp: got %0d exp 0", issue_warp); end
    checks++; if (issue_inst !== '0) begin errors++; $display("FAIL reset_issue_inst: got %0h exp 0", issue_inst); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d exp 0", stall_cnt); end
    checks++; if (rec_new_reg !== 5'd0) begin errors++; $display("FAIL reset_rec_new_reg: got %0d exp 0", rec_new_reg); end
    checks++; if (inst_ready !== 4'hF) begin errors++; $display("FAIL reset_inst_ready: got %0h exp f", inst_ready); end
  endtask

  task automatic test_basic;
    inst[0] = '{rd: 5'd5, rs1: 5'd1, rs2: 5'd2, payload: 32'hA0};
    inst_valid = 4'b0001;
    tick;
    inst_valid = '0;
    smp;
    checks++; if (rec_warp_num !== 2'd0) begin errors++; $display("FAIL basic_rec_warp: got %0d exp 0", rec_warp_num); end
    checks++; if (rec_new_reg !== 5'd5) begin errors++; $display("FAIL basic_rec_reg: got %0d exp 5", rec_new_reg); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b exp 0", issue_valid); end
    tick; smp;
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_valid: got %0b exp 1", issue_valid); end
    checks++; if (issue_warp !== 2'd0) begin errors++; $display("FAIL basic_issue_warp: got %0d exp 0", issue_warp); end
    checks++; if (issue_inst.payload !== 32'hA0) begin errors++; $display("FAIL basic_payload: got %0h exp a0", issue_inst.payload); end
    checks++; if (rec_new_reg !== 5'd0) begin errors++; $display("FAIL basic_no_rec: got %0d exp 0", rec_new_reg); end
    tick; smp;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_clear: got %0b exp 0", issue_valid); end
  endtask

  task automatic test_hazard;
    sb_regs[1][0] = 5'd7;
    inst[1] = '{rd: 5'd3, rs1: 5'd7, rs2: 5'd0, payload: 32'hB1};
    inst_valid = 4'b0010;
    tick;
    inst_valid = '0;
    for (int k = 0; k < 3; k++) begin
      smp;
      checks++; if (rec_new_reg !== 5'd0) begin errors++; $display("FAIL hazard_rec_%0d: got %0d exp 0", k, rec_new_reg); end
      checks++; if (stall_cnt !== 16'(k)) begin errors++; $display("FAIL hazard_stall_%0d: got %0d exp %0d", k, stall_cnt, k); end
      checks++; if (inst_ready[1] !== 1'b0) begin errors++; $display("FAIL hazard_ready_%0d: got %0b exp 0", k, inst_ready[1]); end
      tick;
    end
    sb_regs[1][0] = 5'd0;
    smp;
    checks++; if (rec_warp_num !== 2'd1) begin errors++; $display("FAIL hazard_clear_warp: got %0d exp 1", rec_warp_num); end
    checks++; if (rec_new_reg !== 5'd3) begin errors++; $display("FAIL hazard_clear_reg: got %0d exp 3", rec_new_reg); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL hazard_stall_final: got %0d exp 3", stall_cnt); end
    tick; smp;
    checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'd1) begin errors++; $display("FAIL hazard_issue: got v=%0b w=%0d exp v=1 w=1", issue_valid, issue_warp); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL hazard_stall_hold: got %0d exp 3", stall_cnt); end
    tick;
  endtask

  task automatic test_round_robin;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset;
    for (int w = 0; w < 4; w++)
      inst[w] = '{rd: 5'(10 + w), rs1: 5'd0, rs2: 5'd0, payload: 32'(w)};
    inst_valid = 4'hF;
    tick;
    for (int k = 0; k < 5; k++) begin
      smp;
      checks++; if (rec_warp_num !== 2'(exp_order[k])) begin errors++; $display("FAIL rr_rec_warp_%0d: got %0d exp %0d", k, rec_warp_num, exp_order[k]); end
      checks++; if (rec_new_reg !== 5'(10 + exp_order[k])) begin errors++; $display("FAIL rr_rec_reg_%0d: got %0d exp %0d", k, rec_new_reg, 10 + exp_order[k]); end
      if (k > 0) begin
        checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'(exp_order[k-1])) begin errors++; $display("FAIL rr_issue_%0d: got v=%0b w=%0d exp v=1 w=%0d", k, issue_valid, issue_warp, exp_order[k-1]); end
      end
      tick;
    end
  endtask

  // Continues from test_round_robin: all four buffers full, warp 0 last issued.
  task automatic test_backpressure;
    inst_valid = '0;
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'd0 || issue_inst.rd !== 5'd10) begin errors++; $display("FAIL bp_hold_%0d: got v=%0b w=%0d rd=%0d exp v=1 w=0 rd=10", k, issue_valid, issue_warp, issue_inst.rd); end
      checks++; if (rec_new_reg !== 5'd0) begin errors++; $display("FAIL bp_no_rec_%0d: got %0d exp 0", k, rec_new_reg); end
      checks++; if (inst_ready !== 4'h0) begin errors++; $display("FAIL bp_inst_ready_%0d: got %0h exp 0", k, inst_ready); end
      tick;
    end
    issue_ready = 1'b1;
    smp;
    checks++; if (rec_warp_num !== 2'd1 || rec_new_reg !== 5'd11) begin errors++; $display("FAIL bp_resume_rec: got w=%0d r=%0d exp w=1 r=11", rec_warp_num, rec_new_reg); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d exp 3", stall_cnt); end
    tick; smp;
    checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'd1) begin errors++; $display("FAIL bp_resume_issue: got v=%0b w=%0d exp v=1 w=1", issue_valid, issue_warp); end
    tick; tick; tick; tick;
    smp;
    checks++; if (issue_valid !== 1'b0 || inst_ready !== 4'hF) begin errors++; $display("FAIL bp_drain: got v=%0b rdy=%0h exp v=0 rdy=f", issue_valid, inst_ready); end
  endtask

  task automatic test_capacity;
    do_reset;
    sb_regs[2][0] = 5'd3;
    sb_regs[2][1] = 5'd4;
    sb_regs[2][2] = 5'd6;
    sb_regs[2][3] = 5'd8;
    inst[2] = '{rd: 5'd9, rs1: 5'd1, rs2: 5'd2, payload: 32'hC1};
    inst_valid = 4'b0100;
    tick;
    inst_valid = '0;
    for (int k = 0; k < 2; k++) begin
      smp;
      checks++; if (rec_new_reg !== 5'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL cap_blocked_%0d: got r=%0d v=%0b exp r=0 v=0", k, rec_new_reg, issue_valid); end
      checks++; if (inst_ready[2] !== 1'b0) begin errors++; $display("FAIL cap_ready_%0d: got %0b exp 0", k, inst_ready[2]); end
      tick;
    end
    do_reset;
    inst[2] = '{rd: 5'd0, rs1: 5'd1, rs2: 5'd2, payload: 32'hC2};
    inst_valid = 4'b0100;
    tick;
    inst_valid = '0;
    smp;
    checks++; if (rec_warp_num !== 2'd2 || rec_new_reg !== 5'd0) begin errors++; $display("FAIL cap_rd0_rec: got w=%0d r=%0d exp w=2 r=0", rec_warp_num, rec_new_reg); end
    tick; smp;
    checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'd2 || issue_inst.payload !== 32'hC2) begin errors++; $display("FAIL cap_rd0_issue: got v=%0b w=%0d p=%0h exp v=1 w=2 p=c2", issue_valid, issue_warp, issue_inst.payload); end
    sb_regs = '0;
  endtask

  task automatic test_rdy_reset;
    do_reset;
    inst[1] = '{rd: 5'd20, rs1: 5'd0, rs2: 5'd0, payload: 32'hD1};
    inst[3] = '{rd: 5'd21, rs1: 5'd0, rs2: 5'd0, payload: 32'hD3};
    inst_valid = 4'b1010;
    tick;
    inst_valid = '0;
    smp;
    checks++; if (rec_warp_num !== 2'd1 || rec_new_reg !== 5'd20) begin errors++; $display("FAIL rdy_first_rec: got w=%0d r=%0d exp w=1 r=20", rec_warp_num, rec_new_reg); end
    tick;
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      checks++; if (issue_valid !== 1'b1 || issue_warp !== 2'd1) begin errors++; $display("FAIL rdy_hold_%0d: got v=%0b w=%0d exp v=1 w=1", k, issue_valid, issue_warp); end
      checks++; if (rec_new_reg !== 5'd0 || inst_ready !== 4'h0) begin errors++; $display("FAIL rdy_quiet_%0d: got r=%0d rdy=%0h exp r=0 rdy=0", k, rec_new_reg, inst_ready); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rdy_stall_%0d: got %0d exp 0", k, stall_cnt); end
      tick;
    end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    rdy = 1'b1;
    smp;
    checks++; if (issue_valid !== 1'b0 || issue_warp !== 2'd0) begin errors++; $display("FAIL rst_out: got v=%0b w=%0d exp v=0 w=0", issue_valid, issue_warp); end
    checks++; if (stall_cnt !== 16'd0 || inst_ready !== 4'hF) begin errors++; $display("FAIL rst_state: got s=%0d rdy=%0h exp s=0 rdy=f", stall_cnt, inst_ready); end
    inst[0] = '{rd: 5'd22, rs1: 5'd0, rs2: 5'd0, payload: 32'hD0};
    inst_valid = 4'b1001;
    tick;
    inst_valid = '0;
    smp;
    checks++; if (rec_warp_num !== 2'd0 || rec_new_reg !== 5'd22) begin errors++; $display("FAIL rst_priority: got w=%0d r=%0d exp w=0 r=22", rec_warp_num, rec_new_reg); end
  endtask

  initial begin
    inst = '0;
    sb_regs = '0;
    test_reset;
    test_basic;
    test_hazard;
    test_round_robin;
    test_backpressure;
    test_capacity;
    test_rdy_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
